// File: rtl/straight_threat_checker.sv
// Straight-line check detector: walks the scanner through UP/LEFT/RIGHT/DOWN from the king
// square and flags enemy rooks/queens. Define KING_ADJ_EN to also flag an adjacent enemy king.
module straight_threat_checker #(
  parameter int unsigned SCAN_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] kingPosition,
  input  logic       kingColor,
  input  logic [5:0] nearestPosition,
  input  logic [3:0] nearestPiece,
  output logic [5:0] scanPosition,
  output logic [1:0] scanDirection,
  output logic       busy,
  output logic       done,
  output logic       inCheck,
  output logic [3:0] attackMask,
  output logic [5:0] attackerPosition,
  output logic [3:0] attackerPiece
);

  localparam int unsigned CntW = (SCAN_LATENCY < 1) ? 1 : $clog2(SCAN_LATENCY + 1);
  localparam logic [CntW-1:0] LatCnt = CntW'(SCAN_LATENCY);

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirLeft  = 2'b01;
  localparam logic [1:0] DirRight = 2'b10;
  localparam logic [1:0] DirDown  = 2'b11;

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      pos_q, pos_d;
  logic [1:0]      dir_q, dir_d;
  logic            color_q, color_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            in_check_q, in_check_d;
  logic [3:0]      mask_q, mask_d;
  logic [5:0]      att_pos_q, att_pos_d;
  logic [3:0]      att_piece_q, att_piece_d;

  logic [2:0] row, col;
  logic       on_board;
  logic       is_slider;
  logic       is_enemy;
  logic       king_adj;
  logic       hit;

  assign row = pos_q[2:0];
  assign col = pos_q[5:3];

  // Off-board directions are forced empty so stale scanner data never counts.
  always_comb begin
    on_board = 1'b0;
    unique case (dir_q)
      DirUp:    on_board = (row != 3'd0);
      DirLeft:  on_board = (col != 3'd0);
      DirRight: on_board = (col != 3'd7);
      DirDown:  on_board = (row != 3'd7);
      default:  on_board = 1'b0;
    endcase
  end

  assign is_slider = (nearestPiece[2:0] == 3'b100) || (nearestPiece[2:0] == 3'b101);
  assign is_enemy  = (nearestPiece[3] != color_q);

`ifdef KING_ADJ_EN
  logic [5:0] adj_pos;

  // Square one step away in the current direction; only meaningful when on_board.
  always_comb begin
    adj_pos = pos_q;
    unique case (dir_q)
      DirUp:    adj_pos = pos_q - 6'd1;
      DirLeft:  adj_pos = pos_q - 6'd8;
      DirRight: adj_pos = pos_q + 6'd8;
      DirDown:  adj_pos = pos_q + 6'd1;
      default:  adj_pos = pos_q;
    endcase
  end

  assign king_adj = (nearestPiece[2:0] == 3'b110) && (nearestPosition == adj_pos);
`else
  assign king_adj = 1'b0;
`endif

  assign hit = on_board && is_enemy && (is_slider || king_adj);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    color_d     = color_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_check_d  = in_check_q;
    mask_d      = mask_q;
    att_pos_d   = att_pos_q;
    att_piece_d = att_piece_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pos_d       = kingPosition;
          color_d     = kingColor;
          mask_d      = 4'b0000;
          in_check_d  = 1'b0;
          att_pos_d   = 6'd0;
          att_piece_d = 4'd0;
          dir_d       = DirUp;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = StScan;
        end
      end

      StScan: begin
        if (cnt_q != LatCnt) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (hit) begin
            mask_d[dir_q] = 1'b1;
            in_check_d    = 1'b1;
            if (!in_check_q) begin
              att_pos_d   = nearestPosition;
              att_piece_d = nearestPiece;
            end
          end
          if (dir_q == DirDown) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StReport;
          end else begin
            dir_d = dir_q + 2'd1;
          end
        end
      end

      // One-cycle hold so a start coincident with done is not accepted.
      StReport: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pos_q       <= 6'd0;
      dir_q       <= DirUp;
      color_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_check_q  <= 1'b0;
      mask_q      <= 4'b0000;
      att_pos_q   <= 6'd0;
      att_piece_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      color_q     <= color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_check_q  <= in_check_d;
      mask_q      <= mask_d;
      att_pos_q   <= att_pos_d;
      att_piece_q <= att_piece_d;
    end
  end

  assign scanPosition     = pos_q;
  assign scanDirection    = dir_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign inCheck          = in_check_q;
  assign attackMask       = mask_q;
  assign attackerPosition = att_pos_q;
  assign attackerPiece    = att_piece_q;

endmodule

// File: tb/tb_straight_threat_checker.sv
// Scoreboard bench for straight_threat_checker with a behavioural 2-cycle-latency scanner model.
module tb_straight_threat_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] kingPosition;
  logic       kingColor;
  logic [5:0] nearestPosition;
  logic [3:0] nearestPiece;
  logic [5:0] scanPosition;
  logic [1:0] scanDirection;
  logic       busy;
  logic       done;
  logic       inCheck;
  logic [3:0] attackMask;
  logic [5:0] attackerPosition;
  logic [3:0] attackerPiece;

  straight_threat_checker #(.SCAN_LATENCY(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .kingPosition    (kingPosition),
    .kingColor       (kingColor),
    .nearestPosition (nearestPosition),
    .nearestPiece    (nearestPiece),
    .scanPosition    (scanPosition),
    .scanDirection   (scanDirection),
    .busy            (busy),
    .done            (done),
    .inCheck         (inCheck),
    .attackMask      (attackMask),
    .attackerPosition(attackerPosition),
    .attackerPiece   (attackerPiece)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scanner model: board of piece codes, nearest piece along a ray, delayed two edges.
  logic [3:0] board [64];
  logic       stale = 1'b0;
  logic [9:0] s1, s2;

  function automatic logic [9:0] look(input logic [5:0] p, input logic [1:0] d);
    int r = int'(p[2:0]);
    int c = int'(p[5:3]);
    int dr = 0;
    int dc = 0;
    logic [5:0] idx;
    case (d)
      2'b00:   dr = -1;
      2'b01:   dc = -1;
      2'b10:   dc = 1;
      default: dr = 1;
    endcase
    r += dr;
    c += dc;
    if (r < 0 || r > 7 || c < 0 || c > 7) return stale ? {6'd0, 4'hC} : {p, 4'h0};
    while (r >= 0 && r <= 7 && c >= 0 && c <= 7) begin
      idx = 6'(c * 8 + r);
      if (board[idx] != 4'h0) return {idx, board[idx]};
      r += dr;
      c += dc;
    end
    return {p, 4'h0};
  endfunction

  always @(posedge clk) begin
    s1 <= look(scanPosition, scanDirection);
    s2 <= s1;
  end
  assign {nearestPosition, nearestPiece} = s2;

  typedef struct {
    logic [3:0] mask;
    logic [5:0] pos;
    logic [3:0] piece;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done_prev) check("done_one_cycle", 32'(done), 32'd0);
    done_prev = done;
    if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending scan (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("attackMask", 32'(attackMask), 32'(e.mask));
        check("inCheck", 32'(inCheck), 32'(e.mask != 4'b0000));
        check("attackerPosition", 32'(attackerPosition), 32'(e.pos));
        check("attackerPiece", 32'(attackerPiece), 32'(e.piece));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 4'h0;
  endtask

  task automatic launch(input logic [5:0] kp, input logic kc, input logic [3:0] m,
                        input logic [5:0] p, input logic [3:0] pc);
    exp_t x;
    @(negedge clk);
    kingPosition = kp;
    kingColor    = kc;
    start        = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    x.mask  = m;
    x.pos   = p;
    x.piece = pc;
    x.cyc   = cyc + 12;
    sb.push_back(x);
    check("busy_after_start", 32'(busy), 32'd1);
    check("scanPosition_latched", 32'(scanPosition), 32'(kp));
    check("dir_after_start", 32'(scanDirection), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    kingPosition = 6'd0;
    kingColor    = 1'b0;
    clear_board();
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_inCheck", 32'(inCheck), 32'd0);
    check("rst_mask", 32'(attackMask), 32'd0);
    check("rst_attpos", 32'(attackerPosition), 32'd0);
    check("rst_attpiece", 32'(attackerPiece), 32'd0);
    check("rst_scanpos", 32'(scanPosition), 32'd0);
    check("rst_scandir", 32'(scanDirection), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // T1: black rook on DOWN ray; king input changes mid-scan must not matter.
    clear_board();
    board[30] = 4'hC;
    launch(6'd27, 1'b0, 4'b1000, 6'd30, 4'hC);
    kingPosition = 6'd0;
    kingColor    = 1'b1;
    wait_done();
    // start coincident with done is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("start_at_done_ignored", 32'(busy), 32'd0);
    check("results_hold", 32'(attackMask), 32'b1000);

    // T2: queen LEFT (first in scan order) and rook DOWN.
    clear_board();
    board[3]  = 4'hD;
    board[31] = 4'hC;
    launch(6'd27, 1'b0, 4'b1010, 6'd3, 4'hD);
    wait_done();

    // T3: own rook and enemy bishop are not straight attackers.
    clear_board();
    board[28] = 4'h4;
    board[19] = 4'hB;
    launch(6'd27, 1'b0, 4'b0000, 6'd0, 4'h0);
    wait_done();

    // T4: corner king; stale rook data on off-board UP/LEFT ignored, real rook DOWN.
    clear_board();
    stale    = 1'b1;
    board[1] = 4'hC;
    launch(6'd0, 1'b0, 4'b1000, 6'd1, 4'hC);
    wait_done();
    stale = 1'b0;

    // T5: black king, white rook UP, own queen LEFT, far white king RIGHT.
    clear_board();
    board[24] = 4'h4;
    board[11] = 4'hD;
    board[59] = 4'h6;
    launch(6'd27, 1'b1, 4'b0001, 6'd24, 4'h4);
    wait_done();

    // T6: adjacent enemy king on RIGHT.
    clear_board();
    board[35] = 4'hE;
`ifdef KING_ADJ_EN
    launch(6'd27, 1'b0, 4'b0100, 6'd35, 4'hE);
`else
    launch(6'd27, 1'b0, 4'b0000, 6'd0, 4'h0);
`endif
    wait_done();

    // T7: reset at edge 5 aborts the scan, then a clean scan with a start during busy.
    clear_board();
    board[30] = 4'hC;
    launch(6'd27, 1'b0, 4'b1000, 6'd30, 4'hC);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    void'(sb.pop_back());
    #2;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_mask", 32'(attackMask), 32'd0);
    check("abort_scanpos", 32'(scanPosition), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_board();
    launch(6'd27, 1'b0, 4'b0000, 6'd0, 4'h0);
    repeat (3) @(negedge clk);
    kingPosition = 6'd0;
    board[35]    = 4'hC;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored_pos", 32'(scanPosition), 32'd27);
    board[35] = 4'h0;
    wait_done();
    repeat (20) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
